// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Provides default widths and a saturating increment.
package stream_demux_pkg;

  localparam int DW_DEF  = 8;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;

  // Holds at vmax instead of wrapping.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] vmax
  );
    return (v >= vmax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel.
// Ports: clk, rst, i_load/i_data (fill), i_ready (drain), o_valid/o_data.
module demux_chan_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Load wins over drain so a same-cycle refill keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demux with unicast/broadcast and drop count.
// Ports: in_* producer handshake, out_* per-channel handshakes, drop_cnt.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DW  = DW_DEF,
  parameter  int NCH = NCH_DEF,
  parameter  int CW  = CW_DEF,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [CW-1:0]     drop_cnt
);

  logic [NCH-1:0] w_free;
  logic [NCH-1:0] w_sel_oh;
  logic [NCH-1:0] w_load;
  logic           w_inrange;
  logic           w_acc;
  logic           w_drop;
  logic [CW-1:0]  r_drop;

  // Extra bit keeps the compare meaningful for any NCH.
  assign w_inrange = ({1'b0, in_sel} < (SW+1)'(NCH));

  assign in_ready = bcast
                  ? &w_free
                  : (|(w_sel_oh & w_free)) | ~w_inrange;

  assign w_acc  = in_valid & in_ready;
  assign w_drop = w_acc & ~bcast & ~w_inrange;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign w_free[k]   = ~out_valid[k] | out_ready[k];
    assign w_sel_oh[k] = (in_sel == SW'(k));
    assign w_load[k]   = w_acc & (bcast | w_sel_oh[k]);

    demux_chan_reg #(
      .DW (DW)
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*DW +: DW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop) begin
      r_drop <= CW'(sat_inc(32'(r_drop), 32'({CW{1'b1}})));
    end
  end

  assign drop_cnt = r_drop;

endmodule
